// File: rtl/rv32i_types_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_types_pkg
//   Shared types for the two-stage RV32I pipeline.
//   - word_t        : 32-bit machine word
//   - RV32I_NOP     : canonical NOP (addi x0, x0, 0)
//   - fetch_state_t : fetch stage controller states
//   - is_misaligned : true when an instruction address is not word aligned
// ----------------------------------------------------------------------------
package rv32i_types_pkg;

    typedef logic [31:0] word_t;

    localparam word_t RV32I_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FETCH,
        DROP,
        SKID,
        FAULT,
        HALTED
    } fetch_state_t;

    function automatic logic is_misaligned(input word_t addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// ----------------------------------------------------------------------------
// fetch_stage_if
//   Instruction memory request/response bundle.
//   imem_ren   : read request (fetch side drives)
//   imem_addr  : word address of the request (fetch side drives)
//   imem_busy  : 1 while the request is still in progress (memory drives)
//   imem_rdata : fetched word, valid when imem_busy == 0 (memory drives)
//   master = fetch stage, slave = instruction memory.
// ----------------------------------------------------------------------------
interface fetch_stage_if;
    import rv32i_types_pkg::*;

    logic  imem_ren;
    word_t imem_addr;
    logic  imem_busy;
    word_t imem_rdata;

    modport master (
        output imem_ren,
        output imem_addr,
        input  imem_busy,
        input  imem_rdata
    );

    modport slave (
        input  imem_ren,
        input  imem_addr,
        output imem_busy,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_buffer.sv
// ----------------------------------------------------------------------------
// fetch_buffer
//   Fetch/execute output register plus a one-entry skid slot.
//   CLK, nRST      : clock, synchronous active-low reset
//   flush          : drop the output entry and the skid entry
//   hold           : execute stage is stalled; keep the output entry
//   load           : write load_* into the output register
//   skid_push      : park skid_*_in in the skid slot
//   skid_pop       : move the skid entry into the output register
//   out_valid/out_instr/out_pc/out_fault : current output entry
//   Priority: reset > flush > skid_pop > load > release (clear when !hold).
// ----------------------------------------------------------------------------
module fetch_buffer
    import rv32i_types_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0200
)
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  flush,
    input  logic  hold,
    input  logic  load,
    input  word_t load_instr,
    input  word_t load_pc,
    input  logic  load_fault,
    input  logic  skid_push,
    input  word_t skid_instr_in,
    input  word_t skid_pc_in,
    input  logic  skid_pop,
    output logic  out_valid,
    output word_t out_instr,
    output word_t out_pc,
    output logic  out_fault
);

    logic  skid_valid;
    word_t skid_instr;
    word_t skid_pc;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            out_valid  <= 1'b0;
            out_instr  <= RV32I_NOP;
            out_pc     <= RESET_PC;
            out_fault  <= 1'b0;
            skid_valid <= 1'b0;
            skid_instr <= RV32I_NOP;
            skid_pc    <= RESET_PC;
        end else if (flush) begin
            out_valid  <= 1'b0;
            out_instr  <= RV32I_NOP;
            out_fault  <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (skid_pop && skid_valid) begin
                out_valid  <= 1'b1;
                out_instr  <= skid_instr;
                out_pc     <= skid_pc;
                out_fault  <= 1'b0;
                skid_valid <= 1'b0;
            end else if (load) begin
                out_valid <= 1'b1;
                out_instr <= load_instr;
                out_pc    <= load_pc;
                out_fault <= load_fault;
            end else if (!hold) begin
                // Consumed by execute and nothing new arrived.
                out_valid <= 1'b0;
                out_instr <= RV32I_NOP;
                out_fault <= 1'b0;
            end

            if (skid_push) begin
                skid_valid <= 1'b1;
                skid_instr <= skid_instr_in;
                skid_pc    <= skid_pc_in;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// ----------------------------------------------------------------------------
// fetch_stage
//   First pipeline stage: owns the PC, reads instruction memory and presents
//   the fetched word to the control unit through the fetch/execute register.
//   CLK, nRST    : clock, synchronous active-low reset
//   imem         : instruction memory request/response (master side)
//   stall        : execute stage cannot accept a new instruction
//   redirect     : load redirect_pc as next PC and flush the held instruction
//   redirect_pc  : redirect target
//   halt         : stop fetching; only reset leaves the halted state
//   fetch_valid  : fetch_instr/fetch_pc hold a live instruction
//   fetch_instr  : instruction word (NOP when not valid)
//   fetch_pc     : PC of fetch_instr
//   fetch_pc4    : fetch_pc + 4 (wraps)
//   fault_fetch  : fetch_pc is misaligned and must not execute
//   Priority at each edge: reset > halt > redirect > normal fetch.
// ----------------------------------------------------------------------------
module fetch_stage
    import rv32i_types_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0200
)
(
    input  logic                 CLK,
    input  logic                 nRST,
    fetch_stage_if.master        imem,
    input  logic                 stall,
    input  logic                 redirect,
    input  word_t                redirect_pc,
    input  logic                 halt,
    output logic                 fetch_valid,
    output word_t                fetch_instr,
    output word_t                fetch_pc,
    output word_t                fetch_pc4,
    output logic                 fault_fetch
);

    fetch_state_t state, next_state;
    word_t        pc, next_pc;
    // drop_pending: an abandoned request is still in flight while imem_ren is low
    logic         drop_pending, next_drop_pending;
    // drop_addr: address of the abandoned request, held on the bus in DROP
    word_t        drop_addr, next_drop_addr;

    logic         req_ren;
    word_t        req_addr;
    logic         in_flight;

    logic         buf_flush;
    logic         buf_load;
    word_t        load_instr;
    word_t        load_pc;
    logic         load_fault;
    logic         skid_push;
    logic         skid_pop;

    // ------------------------------------------------------------------
    // Memory request
    // ------------------------------------------------------------------
    always_comb begin
        req_ren  = 1'b0;
        req_addr = pc;
        case (state)
            FETCH: req_ren = 1'b1;
            DROP: begin
                req_ren  = 1'b1;
                req_addr = drop_addr;
            end
            default: ;
        endcase
    end

    assign imem.imem_ren  = req_ren;
    assign imem.imem_addr = {req_addr[31:2], 2'b00};

    // A request that will not complete at this edge.
    assign in_flight = imem.imem_busy && (req_ren || drop_pending);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            drop_pending <= 1'b0;
            drop_addr    <= RESET_PC;
        end else begin
            state        <= next_state;
            pc           <= next_pc;
            drop_pending <= next_drop_pending;
            drop_addr    <= next_drop_addr;
        end
    end

    // ------------------------------------------------------------------
    // Next state, PC and buffer controls
    // ------------------------------------------------------------------
    always_comb begin
        next_state        = state;
        next_pc           = pc;
        next_drop_pending = drop_pending && imem.imem_busy;
        next_drop_addr    = (state == FETCH) ? pc : drop_addr;
        buf_flush         = 1'b0;
        buf_load          = 1'b0;
        load_instr        = RV32I_NOP;
        load_pc           = pc;
        load_fault        = 1'b0;
        skid_push         = 1'b0;
        skid_pop          = 1'b0;

        if (state == HALTED) begin
            buf_flush = 1'b1;
        end else if (halt) begin
            next_state        = HALTED;
            buf_flush         = 1'b1;
            next_drop_pending = in_flight;
        end else if (redirect) begin
            buf_flush = 1'b1;
            next_pc   = redirect_pc;
            if (is_misaligned(redirect_pc)) begin
                next_state        = FAULT;
                next_drop_pending = in_flight;
            end else if (in_flight) begin
                next_state        = DROP;
                next_drop_pending = 1'b0;
            end else begin
                // Includes a word completing this cycle: it is discarded.
                next_state        = FETCH;
                next_drop_pending = 1'b0;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (!imem.imem_busy) begin
                        if (!fetch_valid || !stall) begin
                            buf_load   = 1'b1;
                            load_instr = imem.imem_rdata;
                            next_pc    = pc + 32'd4;
                        end else begin
                            // PC advances only when the skid word moves out.
                            skid_push  = 1'b1;
                            next_state = SKID;
                        end
                    end
                end
                DROP: begin
                    if (!imem.imem_busy) begin
                        next_state = FETCH;
                    end
                end
                SKID: begin
                    if (!stall) begin
                        skid_pop   = 1'b1;
                        next_pc    = pc + 32'd4;
                        next_state = FETCH;
                    end
                end
                FAULT: begin
                    buf_load   = 1'b1;
                    load_fault = 1'b1;
                end
                default: next_state = FETCH;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output register and skid entry
    // ------------------------------------------------------------------
    fetch_buffer #(
        .RESET_PC (RESET_PC)
    ) u_buffer (
        .CLK           (CLK),
        .nRST          (nRST),
        .flush         (buf_flush),
        .hold          (stall),
        .load          (buf_load),
        .load_instr    (load_instr),
        .load_pc       (load_pc),
        .load_fault    (load_fault),
        .skid_push     (skid_push),
        .skid_instr_in (imem.imem_rdata),
        .skid_pc_in    (pc),
        .skid_pop      (skid_pop),
        .out_valid     (fetch_valid),
        .out_instr     (fetch_instr),
        .out_pc        (fetch_pc),
        .out_fault     (fault_fetch)
    );

    assign fetch_pc4 = fetch_pc + 32'd4;

endmodule

// File: tb/tb_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. The bench plays instruction memory
//   (imem_busy driven by the stimulus, imem_rdata derived from the address)
//   and the execute stage. Every word fetched to completion is queued with
//   its address; every instruction the execute stage accepts
//   (fetch_valid && !stall) is popped and compared.
// ----------------------------------------------------------------------------
module tb_fetch_stage;
    import rv32i_types_pkg::*;

    logic  CLK = 1'b0;
    logic  nRST;
    logic  stall;
    logic  redirect;
    word_t redirect_pc;
    logic  halt;
    logic  busy;

    logic  fetch_valid;
    word_t fetch_instr;
    word_t fetch_pc;
    word_t fetch_pc4;
    logic  fault_fetch;

    int    checks   = 0;
    int    failures = 0;

    logic [63:0] sb_q[$];
    logic        drop_expected = 1'b0;

    function automatic word_t mem_word(input word_t a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    fetch_stage_if mif ();

    assign mif.imem_busy  = busy;
    assign mif.imem_rdata = busy ? 32'hDEAD_BEEF : mem_word(mif.imem_addr);

    fetch_stage #(
        .RESET_PC (32'h0000_0200)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .imem        (mif),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .fetch_pc    (fetch_pc),
        .fetch_pc4   (fetch_pc4),
        .fault_fetch (fault_fetch)
    );

    always #5 CLK = ~CLK;

    task automatic check_word(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        nRST        = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        halt        = 1'b0;
        busy        = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
    endtask

    // Scoreboard: consumption checked before this cycle's completion is queued.
    always @(negedge CLK) begin
        logic [63:0] entry;
        if (!nRST) begin
            sb_q.delete();
            drop_expected = 1'b0;
        end else begin
            if (fetch_valid && !stall && !fault_fetch) begin
                check_bit("sb_nonempty", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    entry = sb_q.pop_front();
                    check_word("sb_pc", fetch_pc, entry[63:32]);
                    check_word("sb_instr", fetch_instr, entry[31:0]);
                end
            end
            if (mif.imem_ren && !busy) begin
                if (drop_expected)
                    drop_expected = 1'b0;
                else if (!redirect && !halt)
                    sb_q.push_back({mif.imem_addr, mem_word(mif.imem_addr)});
            end
            if (halt || redirect) begin
                sb_q.delete();
                if (mif.imem_ren && busy)
                    drop_expected = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST        = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        halt        = 1'b0;
        busy        = 1'b0;
        tick();
        tick();

        // Reset state
        settle();
        check_bit ("rst_valid", fetch_valid, 1'b0);
        check_word("rst_instr", fetch_instr, RV32I_NOP);
        check_word("rst_pc",    fetch_pc,    32'h0000_0200);
        check_word("rst_pc4",   fetch_pc4,   32'h0000_0204);
        check_bit ("rst_fault", fault_fetch, 1'b0);

        // 1: back-to-back fetches with zero-wait memory
        tick();
        nRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_bit ("seq_ren",  mif.imem_ren, 1'b1);
            check_word("seq_addr", mif.imem_addr, 32'h0000_0200 + 32'(4 * i));
            if (i > 0) begin
                check_bit ("seq_valid", fetch_valid, 1'b1);
                check_word("seq_fpc",   fetch_pc, 32'h0000_0200 + 32'(4 * (i - 1)));
            end
            tick();
        end

        // 2: three busy cycles on the first request
        do_reset();
        busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_bit ("busy_ren",   mif.imem_ren, 1'b1);
            check_word("busy_addr",  mif.imem_addr, 32'h0000_0200);
            check_bit ("busy_valid", fetch_valid, 1'b0);
            tick();
        end
        busy = 1'b0;
        settle();
        check_word("done_addr",  mif.imem_addr, 32'h0000_0200);
        check_bit ("done_valid", fetch_valid, 1'b0);
        tick();
        settle();
        check_bit ("first_valid", fetch_valid, 1'b1);
        check_word("first_pc",    fetch_pc, 32'h0000_0200);
        check_word("first_instr", fetch_instr, mem_word(32'h0000_0200));

        // 3: stall for four cycles with a live instruction
        tick();
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check_word("stall_pc",    fetch_pc, 32'h0000_0204);
            check_word("stall_instr", fetch_instr, mem_word(32'h0000_0204));
            check_bit ("stall_valid", fetch_valid, 1'b1);
            if (k > 0)
                check_bit("skid_ren", mif.imem_ren, 1'b0);
            tick();
        end
        stall = 1'b0;
        settle();
        check_word("release_pc", fetch_pc, 32'h0000_0204);
        tick();
        settle();
        check_word("skid_out_pc",    fetch_pc, 32'h0000_0208);
        check_word("skid_out_instr", fetch_instr, mem_word(32'h0000_0208));
        check_word("after_skid_addr", mif.imem_addr, 32'h0000_020C);
        tick();
        settle();
        check_word("resume_pc", fetch_pc, 32'h0000_020C);

        // 4: redirect while the request to 0x214 is outstanding
        tick();
        busy        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_1000;
        settle();
        check_word("pre_redir_pc", fetch_pc, 32'h0000_0210);
        tick();
        redirect = 1'b0;
        settle();
        check_bit("drop_valid", fetch_valid, 1'b0);
        check_bit("drop_ren",   mif.imem_ren, 1'b1);
        tick();
        busy = 1'b0;
        settle();
        check_bit("drop_done_valid", fetch_valid, 1'b0);
        tick();
        settle();
        check_bit ("redir_ren",   mif.imem_ren, 1'b1);
        check_word("redir_addr",  mif.imem_addr, 32'h0000_1000);
        check_bit ("redir_valid", fetch_valid, 1'b0);
        tick();

        // 5: misaligned redirect coinciding with a completing fetch
        redirect    = 1'b1;
        redirect_pc = 32'h0000_1002;
        settle();
        check_bit ("redir_out_valid", fetch_valid, 1'b1);
        check_word("redir_out_pc",    fetch_pc, 32'h0000_1000);
        check_word("redir_out_instr", fetch_instr, mem_word(32'h0000_1000));
        tick();
        redirect = 1'b0;
        settle();
        check_bit("fault_ren0",   mif.imem_ren, 1'b0);
        check_bit("fault_valid0", fetch_valid, 1'b0);
        tick();
        settle();
        check_bit ("fault_valid", fetch_valid, 1'b1);
        check_bit ("fault_flag",  fault_fetch, 1'b1);
        check_word("fault_pc",    fetch_pc, 32'h0000_1002);
        check_word("fault_instr", fetch_instr, RV32I_NOP);
        check_bit ("fault_ren",   mif.imem_ren, 1'b0);
        tick();
        settle();
        check_bit("fault_hold", fault_fetch, 1'b1);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2000;
        settle();
        check_bit("fault_hold2", fault_fetch, 1'b1);
        tick();
        redirect = 1'b0;
        settle();
        check_bit ("clear_fault", fault_fetch, 1'b0);
        check_bit ("clear_valid", fetch_valid, 1'b0);
        check_bit ("clear_ren",   mif.imem_ren, 1'b1);
        check_word("clear_addr",  mif.imem_addr, 32'h0000_2000);
        tick();

        // 6: halt and redirect together, request outstanding
        busy        = 1'b1;
        halt        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3000;
        settle();
        check_bit ("pre_halt_valid", fetch_valid, 1'b1);
        check_word("pre_halt_pc",    fetch_pc, 32'h0000_2000);
        tick();
        halt = 1'b0;
        settle();
        check_bit("halt_ren",   mif.imem_ren, 1'b0);
        check_bit("halt_valid", fetch_valid, 1'b0);
        tick();
        redirect = 1'b0;
        busy     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_bit("halted_ren",   mif.imem_ren, 1'b0);
            check_bit("halted_valid", fetch_valid, 1'b0);
            tick();
        end

        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        settle();
        check_bit ("rerun_ren",  mif.imem_ren, 1'b1);
        check_word("rerun_addr", mif.imem_addr, 32'h0000_0200);

        // PC wrap at the top of the address space
        tick();
        redirect = 1'b0;
        settle();
        check_word("wrap_addr0", mif.imem_addr, 32'hFFFF_FFFC);
        tick();
        settle();
        check_word("wrap_addr1", mif.imem_addr, 32'h0000_0000);
        check_word("wrap_fpc",   fetch_pc, 32'hFFFF_FFFC);
        check_word("wrap_pc4",   fetch_pc4, 32'h0000_0000);
        tick();
        settle();
        check_word("wrap_fpc2",  fetch_pc, 32'h0000_0000);
        check_word("wrap_pc4b",  fetch_pc4, 32'h0000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
